// File: rtl/difference_fold_stage.sv
// difference_fold_stage
// Folded first-difference stage: d[k] = M(x[k] - x[k-1]), where M reduces its
// argument by multiples of 2*LAMBDA into [-LAMBDA, LAMBDA). The reduction is
// iterative (one correction per enabled cycle, at most MAX_FOLDS), followed by
// saturation if the value is still out of range.
// All state updates on the falling edge of clk; reset is asynchronous, active-low.
// Optional build macro DIFF_FOLD_OVF_EN: enables the sticky saturation flag
// fold_ovf. Without it fold_ovf is tied low (saturation itself still happens).

module difference_fold_stage #(
    parameter int                 WIDTH           = 24,
    parameter int                 FRACTIONAL_BITS = 16,
    parameter logic [WIDTH-1:0]   LAMBDA          = 24'h00C000,
    parameter int                 MAX_FOLDS       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] sample_in,
    output logic             ready_out,
    output logic             valid_out,
    output logic [WIDTH-1:0] fold_out,
    output logic             fold_ovf
);

    // A format needs at least one integer (sign) bit above the fraction.
    if (FRACTIONAL_BITS >= WIDTH) begin : g_bad_format
        $error("difference_fold_stage: FRACTIONAL_BITS must be below WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIFF = 2'd1,
        FOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int CNT_W = (MAX_FOLDS < 1) ? 1 : $clog2(MAX_FOLDS + 1);

    // Fold constants, all in the WIDTH+1 working precision.
    localparam logic signed [WIDTH:0]   ONE_LSB = (WIDTH+1)'(1);
    localparam logic signed [WIDTH:0]   LAM_P   = signed'({1'b0, LAMBDA});
    localparam logic signed [WIDTH:0]   LAM_N   = -LAM_P;
    localparam logic signed [WIDTH:0]   LAM_2   = LAM_P + LAM_P;
    localparam logic signed [WIDTH:0]   SAT_HI  = LAM_P - ONE_LSB;
    localparam logic [CNT_W-1:0]        MAX_CNT = CNT_W'(MAX_FOLDS);

    // True when t already lies in [-LAMBDA, LAMBDA).
    function automatic logic in_range(input logic signed [WIDTH:0] t);
        return (t >= LAM_N) && (t < LAM_P);
    endfunction

    // One fold correction toward the output range.
    function automatic logic signed [WIDTH:0] fold_step(input logic signed [WIDTH:0] t);
        logic signed [WIDTH:0] r;
        r = t;
        if (t >= LAM_P) begin
            r = t - LAM_2;
        end else if (t < LAM_N) begin
            r = t + LAM_2;
        end
        return r;
    endfunction

    // Clamp an out-of-range value to the nearest range edge.
    function automatic logic signed [WIDTH:0] saturate(input logic signed [WIDTH:0] t);
        return t[WIDTH] ? LAM_N : SAT_HI;
    endfunction

    state_t                  state;
    state_t                  state_nxt;
    logic [CNT_W-1:0]        fold_cnt;
    logic signed [WIDTH-1:0] x_in_p0;
    logic signed [WIDTH-1:0] x_prev;
    logic signed [WIDTH:0]   diff_p0;
    logic signed [WIDTH:0]   t_p1;
    logic                    t_ok_p1;
    logic                    cnt_full_p1;

    // Stage p0: first difference of the latched sample against the previous one.
    assign diff_p0     = {x_in_p0[WIDTH-1], x_in_p0} - {x_prev[WIDTH-1], x_prev};

    // Stage p1: fold working value and its range / budget status.
    assign t_ok_p1     = in_range(t_p1);
    assign cnt_full_p1 = (fold_cnt == MAX_CNT);

    assign ready_out   = (state == IDLE);

    // Next-state decode for the accept / difference / fold / output sequence.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (valid_in) begin
                    state_nxt = DIFF;
                end
            end
            DIFF: begin
                state_nxt = FOLD;
            end
            FOLD: begin
                if (t_ok_p1 || cnt_full_p1) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Control state, history sample, fold counter and output registers.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            x_prev    <= '0;
            fold_cnt  <= '0;
            fold_out  <= '0;
            valid_out <= 1'b0;
        end else if (clk_en) begin
            state     <= state_nxt;
            valid_out <= (state == DONE);
            case (state)
                DIFF: begin
                    x_prev   <= x_in_p0;
                    fold_cnt <= '0;
                end
                FOLD: begin
                    if (!t_ok_p1 && !cnt_full_p1) begin
                        fold_cnt <= fold_cnt + 1'b1;
                    end
                end
                DONE: begin
                    fold_out <= t_p1[WIDTH-1:0];
                end
                default: begin
                end
            endcase
        end
    end

    // Datapath registers: sample capture and the iterative fold of t.
    always_ff @(negedge clk) begin
        if (clk_en) begin
            case (state)
                IDLE: begin
                    if (valid_in) begin
                        x_in_p0 <= sample_in;
                    end
                end
                DIFF: begin
                    t_p1 <= diff_p0;
                end
                FOLD: begin
                    if (!t_ok_p1) begin
                        t_p1 <= cnt_full_p1 ? saturate(t_p1) : fold_step(t_p1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef DIFF_FOLD_OVF_EN
    logic sat_p1;

    assign sat_p1 = (state == FOLD) && !t_ok_p1 && cnt_full_p1;

    // Sticky flag: set on any saturation, cleared only by reset.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            fold_ovf <= 1'b0;
        end else if (clk_en && sat_p1) begin
            fold_ovf <= 1'b1;
        end
    end
`else
    assign fold_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_difference_fold_stage.sv
// Directed bench for difference_fold_stage (MAX_FOLDS=2 so saturation is reachable).
`timescale 1ns/1ps

module tb_difference_fold_stage;

    logic        clk;
    logic        reset;
    logic        clk_en;
    logic        valid_in;
    logic [23:0] sample_in;
    logic        ready_out;
    logic        valid_out;
    logic [23:0] fold_out;
    logic        fold_ovf;

    int total;
    int bad;

`ifdef DIFF_FOLD_OVF_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    difference_fold_stage #(
        .WIDTH          (24),
        .FRACTIONAL_BITS(16),
        .LAMBDA         (24'h00C000),
        .MAX_FOLDS      (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .clk_en   (clk_en),
        .valid_in (valid_in),
        .sample_in(sample_in),
        .ready_out(ready_out),
        .valid_out(valid_out),
        .fold_out (fold_out),
        .fold_ovf (fold_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the rising edge; the DUT acts on the falling edge.
    task automatic do_reset();
        @(posedge clk);
        reset = 1'b0;
        @(negedge clk);
        @(posedge clk);
        reset = 1'b1;
    endtask

    // Offer one sample, then wait (bounded) for valid_out; lat=0 on timeout.
    task automatic run_sample(input logic [23:0] d, output logic [23:0] r, output int lat);
        @(posedge clk);
        valid_in  = 1'b1;
        sample_in = d;
        @(negedge clk);
        @(posedge clk);
        valid_in  = 1'b0;
        lat = 0;
        r   = 24'hxxxxxx;
        for (int i = 1; i <= 12 && lat == 0; i++) begin
            @(negedge clk);
            #1;
            if (valid_out === 1'b1) begin
                lat = i;
                r   = fold_out;
            end
        end
    endtask

    task automatic test_reset();
        @(posedge clk);
        reset = 1'b0;
        #1;
        total++;
        if ({ready_out, valid_out, fold_out, fold_ovf} !== {1'b1, 1'b0, 24'h000000, 1'b0}) begin
            bad++;
            $display("FAIL reset_outputs got rdy=%b vld=%b out=%h ovf=%b exp rdy=1 vld=0 out=000000 ovf=0",
                     ready_out, valid_out, fold_out, fold_ovf);
        end
        @(negedge clk);
        @(posedge clk);
        reset = 1'b1;
    endtask

    task automatic test_basic();
        logic [23:0] r;
        int lat;
        run_sample(24'h001000, r, lat);
        total++;
        if (r !== 24'h001000) begin bad++; $display("FAIL basic_first_data got=%h exp=001000", r); end
        total++;
        if (lat !== 3) begin bad++; $display("FAIL basic_first_latency got=%0d exp=3", lat); end
        run_sample(24'h002000, r, lat);
        total++;
        if (r !== 24'h001000) begin bad++; $display("FAIL basic_second_data got=%h exp=001000", r); end
        total++;
        if (lat !== 3) begin bad++; $display("FAIL basic_second_latency got=%0d exp=3", lat); end
    endtask

    task automatic test_fold_pos();
        logic [23:0] r;
        int lat;
        do_reset();
        run_sample(24'h00F000, r, lat);
        total++;
        if (r !== 24'hFF7000) begin bad++; $display("FAIL fold_pos_data got=%h exp=ff7000", r); end
        total++;
        if (lat !== 4) begin bad++; $display("FAIL fold_pos_latency got=%0d exp=4", lat); end
    endtask

    task automatic test_fold_neg();
        logic [23:0] r;
        int lat;
        do_reset();
        run_sample(24'hFF0000, r, lat);
        total++;
        if (r !== 24'h008000) begin bad++; $display("FAIL fold_neg_data got=%h exp=008000", r); end
        total++;
        if (lat !== 4) begin bad++; $display("FAIL fold_neg_latency got=%0d exp=4", lat); end
    endtask

    task automatic test_saturate();
        logic [23:0] r;
        int lat;
        do_reset();
        total++;
        if (fold_ovf !== 1'b0) begin bad++; $display("FAIL sat_ovf_before got=%b exp=0", fold_ovf); end
        run_sample(24'h050000, r, lat);
        total++;
        if (r !== 24'h00BFFF) begin bad++; $display("FAIL sat_data got=%h exp=00bfff", r); end
        total++;
        if (lat !== 5) begin bad++; $display("FAIL sat_latency got=%0d exp=5", lat); end
        total++;
        if (fold_ovf !== OVF_EXP) begin bad++; $display("FAIL sat_ovf got=%b exp=%b", fold_ovf, OVF_EXP); end
        // Zero difference afterwards: flag must stay as it was.
        run_sample(24'h050000, r, lat);
        total++;
        if (r !== 24'h000000) begin bad++; $display("FAIL sat_next_data got=%h exp=000000", r); end
        total++;
        if (lat !== 3) begin bad++; $display("FAIL sat_next_latency got=%0d exp=3", lat); end
        total++;
        if (fold_ovf !== OVF_EXP) begin bad++; $display("FAIL sat_ovf_sticky got=%b exp=%b", fold_ovf, OVF_EXP); end
    endtask

    task automatic test_clk_en();
        logic [23:0] r;
        int lat;
        do_reset();
        @(posedge clk);
        valid_in  = 1'b1;
        sample_in = 24'h00F000;
        @(negedge clk);                 // accept
        @(posedge clk);
        valid_in  = 1'b0;
        @(negedge clk);                 // enabled cycle 1: now in FOLD
        @(posedge clk);
        clk_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            total++;
            if ({valid_out, ready_out, fold_out} !== {1'b0, 1'b0, 24'h000000}) begin
                bad++;
                $display("FAIL clk_en_hold[%0d] got vld=%b rdy=%b out=%h exp vld=0 rdy=0 out=000000",
                         i, valid_out, ready_out, fold_out);
            end
        end
        @(posedge clk);
        clk_en = 1'b1;
        lat = 0;
        r   = 24'hxxxxxx;
        for (int i = 2; i <= 12 && lat == 0; i++) begin
            @(negedge clk);
            #1;
            if (valid_out === 1'b1) begin
                lat = i;
                r   = fold_out;
            end
        end
        total++;
        if (r !== 24'hFF7000) begin bad++; $display("FAIL clk_en_data got=%h exp=ff7000", r); end
        total++;
        if (lat !== 4) begin bad++; $display("FAIL clk_en_latency got=%0d exp=4", lat); end
        // The output pulse is stretched while disabled and ends on the next enabled edge.
        @(posedge clk);
        clk_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            total++;
            if (valid_out !== 1'b1) begin bad++; $display("FAIL clk_en_pulse_hold[%0d] got=%b exp=1", i, valid_out); end
        end
        @(posedge clk);
        clk_en = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if (valid_out !== 1'b0) begin bad++; $display("FAIL clk_en_pulse_end got=%b exp=0", valid_out); end
    endtask

    task automatic test_reset_mid();
        logic [23:0] r;
        int lat;
        logic seen;
        @(posedge clk);
        valid_in  = 1'b1;
        sample_in = 24'h00F000;
        @(negedge clk);
        @(posedge clk);
        valid_in  = 1'b0;
        @(negedge clk);                 // now in FOLD
        @(posedge clk);
        reset = 1'b0;
        #1;
        total++;
        if ({ready_out, valid_out, fold_out, fold_ovf} !== {1'b1, 1'b0, 24'h000000, 1'b0}) begin
            bad++;
            $display("FAIL reset_mid_outputs got rdy=%b vld=%b out=%h ovf=%b exp rdy=1 vld=0 out=000000 ovf=0",
                     ready_out, valid_out, fold_out, fold_ovf);
        end
        repeat (2) @(negedge clk);
        @(posedge clk);
        reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            if (valid_out !== 1'b0) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin bad++; $display("FAIL reset_mid_no_pulse got=%b exp=0", seen); end
        total++;
        if (ready_out !== 1'b1) begin bad++; $display("FAIL reset_mid_ready got=%b exp=1", ready_out); end
        run_sample(24'h000100, r, lat);
        total++;
        if (r !== 24'h000100) begin bad++; $display("FAIL reset_mid_next_data got=%h exp=000100", r); end
        total++;
        if (lat !== 3) begin bad++; $display("FAIL reset_mid_next_latency got=%0d exp=3", lat); end
    endtask

    task automatic test_back_to_back();
        logic [23:0] r;
        int lat;
        // x_prev is 0x000100 here.
        @(posedge clk);
        valid_in  = 1'b1;
        sample_in = 24'h000300;
        @(negedge clk);                 // accept
        @(posedge clk);
        sample_in = 24'h7FFFFF;         // valid_in stays high: must be ignored while busy
        lat = 0;
        r   = 24'hxxxxxx;
        for (int i = 1; i <= 12 && lat == 0; i++) begin
            @(negedge clk);
            #1;
            if (i == 1) begin
                total++;
                if (ready_out !== 1'b0) begin bad++; $display("FAIL b2b_busy_ready got=%b exp=0", ready_out); end
            end
            if (valid_out === 1'b1) begin
                lat = i;
                r   = fold_out;
            end
        end
        total++;
        if (r !== 24'h000200) begin bad++; $display("FAIL b2b_first_data got=%h exp=000200", r); end
        total++;
        if (lat !== 3) begin bad++; $display("FAIL b2b_first_latency got=%0d exp=3", lat); end
        @(posedge clk);
        sample_in = 24'h000200;
        @(negedge clk);                 // accept second sample
        #1;
        total++;
        if (valid_out !== 1'b0) begin bad++; $display("FAIL b2b_single_pulse got=%b exp=0", valid_out); end
        @(posedge clk);
        valid_in = 1'b0;
        lat = 0;
        r   = 24'hxxxxxx;
        for (int i = 1; i <= 12 && lat == 0; i++) begin
            @(negedge clk);
            #1;
            if (valid_out === 1'b1) begin
                lat = i;
                r   = fold_out;
            end
        end
        total++;
        if (r !== 24'hFFFF00) begin bad++; $display("FAIL b2b_second_data got=%h exp=ffff00", r); end
        total++;
        if (lat !== 3) begin bad++; $display("FAIL b2b_second_latency got=%0d exp=3", lat); end
    endtask

    task automatic test_boundary();
        logic [23:0] r;
        int lat;
        do_reset();
        // t = +LAMBDA is out of range and folds to -LAMBDA.
        run_sample(24'h00C000, r, lat);
        total++;
        if (r !== 24'hFF4000) begin bad++; $display("FAIL bound_plus_lambda_data got=%h exp=ff4000", r); end
        total++;
        if (lat !== 4) begin bad++; $display("FAIL bound_plus_lambda_latency got=%0d exp=4", lat); end
        // t = -LAMBDA is in range: no correction.
        run_sample(24'h000000, r, lat);
        total++;
        if (r !== 24'hFF4000) begin bad++; $display("FAIL bound_minus_lambda_data got=%h exp=ff4000", r); end
        total++;
        if (lat !== 3) begin bad++; $display("FAIL bound_minus_lambda_latency got=%0d exp=3", lat); end
        // t = -LAMBDA - 1 LSB folds up to LAMBDA - 1 LSB.
        run_sample(24'hFF3FFF, r, lat);
        total++;
        if (r !== 24'h00BFFF) begin bad++; $display("FAIL bound_below_data got=%h exp=00bfff", r); end
        total++;
        if (lat !== 4) begin bad++; $display("FAIL bound_below_latency got=%0d exp=4", lat); end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b0;
        clk_en    = 1'b1;
        valid_in  = 1'b0;
        sample_in = 24'h000000;
        repeat (2) @(negedge clk);

        test_reset();
        test_basic();
        test_fold_pos();
        test_fold_neg();
        test_saturate();
        test_clk_en();
        test_reset_mid();
        test_back_to_back();
        test_boundary();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
